// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad matrix scanner.
//   - FSM state encodings for the scan sequencer (DRIVE, SETTLE, SAMPLE, EMIT)
//   - Counter widths for the settle timer and the per-key debounce counters
//   - idx_width(): width of an index into n items, never less than 1 bit
package keypad_pkg;

    localparam int unsigned StateW     = 2;
    localparam int unsigned SettleCntW = 8;
    localparam int unsigned DbCntW     = 4;

    localparam logic [StateW-1:0] StDrive  = 2'd0;
    localparam logic [StateW-1:0] StSettle = 2'd1;
    localparam logic [StateW-1:0] StSample = 2'd2;
    localparam logic [StateW-1:0] StEmit   = 2'd3;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/keypad_key_bank.sv
// Per-key debounce bank: one saturating-by-flip counter and one stable bit per key.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   col_i          column currently being sampled
//   sample_i       raw row levels for that column, 1 = pressed
//   strobe_i       one-cycle pulse: apply sample_i to the keys of col_i
//   flag_o         combinational, valid with strobe_i: rows whose stable state flips
//                  and that must be reported as events
//   key_state_o    debounced state of all keys, bit index = col*p_ROWS+row
//
// Build option KEYPAD_SCAN_RELEASE_EVT_EN: when defined, releases raise flag_o too;
// otherwise only presses do and releases update key_state_o silently.
module keypad_key_bank
    import keypad_pkg::*;
#(
    parameter int unsigned p_COLS      = 4,
    parameter int unsigned p_ROWS      = 4,
    parameter int unsigned p_DB_ROUNDS = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [idx_width(p_COLS)-1:0] col_i,
    input  logic [p_ROWS-1:0]            sample_i,
    input  logic                         strobe_i,
    output logic [p_ROWS-1:0]            flag_o,
    output logic [p_COLS*p_ROWS-1:0]     key_state_o
);

    localparam int unsigned NKeys = p_COLS * p_ROWS;
    localparam int unsigned KeyW  = idx_width(NKeys);

    logic [DbCntW-1:0] cnt_q [NKeys];
    logic [DbCntW-1:0] cnt_d [NKeys];
    logic [NKeys-1:0]  stable_q, stable_d;
    logic [KeyW-1:0]   key_idx [p_ROWS];

    always_comb begin
        for (int r = 0; r < int'(p_ROWS); r++) begin
            key_idx[r] = KeyW'(int'(col_i) * int'(p_ROWS) + r);
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        flag_o   = '0;
        if (strobe_i) begin
            for (int r = 0; r < int'(p_ROWS); r++) begin
                if (sample_i[r] == stable_q[key_idx[r]]) begin
                    // Any agreeing sample restarts the run of differing samples.
                    cnt_d[key_idx[r]] = '0;
                end else if (cnt_q[key_idx[r]] == DbCntW'(p_DB_ROUNDS - 1)) begin
                    stable_d[key_idx[r]] = sample_i[r];
                    cnt_d[key_idx[r]]    = '0;
`ifdef KEYPAD_SCAN_RELEASE_EVT_EN
                    flag_o[r] = 1'b1;
`else
                    flag_o[r] = sample_i[r];
`endif
                end else begin
                    cnt_d[key_idx[r]] = cnt_q[key_idx[r]] + DbCntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stable_q <= '0;
            for (int k = 0; k < int'(NKeys); k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign key_state_o = stable_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad matrix scan controller. Drives one active-low column at a time, waits for the
// rows to settle, samples them through a 2-flop synchroniser, debounces every key and
// reports debounced changes through a single-entry valid/ready event port.
//
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   ov_col_n         column drive, active-low, at most one bit low
//   iv_row_n         row sense, active-low, asynchronous to i_clk
//   ov_key_state     debounced key state, 1 = pressed, bit = col*p_ROWS+row
//   o_evt_valid      event available; code/press held until accepted
//   i_evt_ready      consumer accepts the event
//   ov_evt_code      key index col*p_ROWS+row
//   o_evt_press      1 = press, 0 = release
//   o_sweep_tick     one-cycle pulse as the last column leaves EMIT
//
// Build option KEYPAD_SCAN_RELEASE_EVT_EN: when defined, releases are reported as events
// with o_evt_press = 0; otherwise releases are silent and o_evt_press is tied to 1.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned p_COLS      = 4,
    parameter int unsigned p_ROWS      = 4,
    parameter int unsigned p_SETTLE    = 4,
    parameter int unsigned p_DB_ROUNDS = 3
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    output logic [p_COLS-1:0]                   ov_col_n,
    input  logic [p_ROWS-1:0]                   iv_row_n,
    output logic [p_COLS*p_ROWS-1:0]            ov_key_state,
    output logic                                o_evt_valid,
    input  logic                                i_evt_ready,
    output logic [idx_width(p_COLS*p_ROWS)-1:0] ov_evt_code,
    output logic                                o_evt_press,
    output logic                                o_sweep_tick
);

    localparam int unsigned NKeys = p_COLS * p_ROWS;
    localparam int unsigned CodeW = idx_width(NKeys);
    localparam int unsigned ColW  = idx_width(p_COLS);
    localparam int unsigned RowW  = idx_width(p_ROWS);

    logic [p_ROWS-1:0]     row_meta_q, row_sync_q;
    logic [StateW-1:0]     state_q, state_d;
    logic [SettleCntW-1:0] settle_q, settle_d;
    logic [ColW-1:0]       col_q, col_d;
    logic [p_COLS-1:0]     col_n_q, col_n_d;
    logic [p_ROWS-1:0]     pending_q, pending_d;
    logic [p_ROWS-1:0]     flip_flags;
    logic [RowW-1:0]       sel_row;
    logic [CodeW-1:0]      sel_code;
    logic                  in_emit, emit_busy, last_col;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
        end else begin
            row_meta_q <= iv_row_n;
            row_sync_q <= row_meta_q;
        end
    end

    keypad_key_bank #(
        .p_COLS      (p_COLS),
        .p_ROWS      (p_ROWS),
        .p_DB_ROUNDS (p_DB_ROUNDS)
    ) u_key_bank (
        .clk_i       (i_clk),
        .rst_i       (i_rst),
        .col_i       (col_q),
        .sample_i    (~row_sync_q),
        .strobe_i    (state_q == StSample),
        .flag_o      (flip_flags),
        .key_state_o (ov_key_state)
    );

    // Lowest-indexed pending row is presented first.
    always_comb begin
        sel_row = '0;
        for (int r = int'(p_ROWS) - 1; r >= 0; r--) begin
            if (pending_q[r]) begin
                sel_row = RowW'(r);
            end
        end
    end

    assign sel_code  = CodeW'(int'(col_q) * int'(p_ROWS) + int'(sel_row));
    assign in_emit   = (state_q == StEmit);
    assign emit_busy = in_emit && (|pending_q);
    assign last_col  = (col_q == ColW'(p_COLS - 1));

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        col_d     = col_q;
        col_n_d   = col_n_q;
        pending_d = pending_q;
        case (state_q)
            StDrive: begin
                col_n_d  = ~(p_COLS'(1) << col_q);
                settle_d = SettleCntW'(p_SETTLE - 1);
                state_d  = StSettle;
            end
            StSettle: begin
                if (settle_q == '0) begin
                    state_d = StSample;
                end else begin
                    settle_d = settle_q - SettleCntW'(1);
                end
            end
            StSample: begin
                pending_d = flip_flags;
                state_d   = StEmit;
            end
            StEmit: begin
                if (pending_q == '0) begin
                    col_d   = last_col ? '0 : col_q + ColW'(1);
                    state_d = StDrive;
                end else if (i_evt_ready) begin
                    // Scan stays stalled here with the column still driven.
                    pending_d[sel_row] = 1'b0;
                end
            end
            default: begin
                state_d = StDrive;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StDrive;
            settle_q  <= '0;
            col_q     <= '0;
            col_n_q   <= '1;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            col_q     <= col_d;
            col_n_q   <= col_n_d;
            pending_q <= pending_d;
        end
    end

    assign ov_col_n     = col_n_q;
    assign o_evt_valid  = emit_busy;
    assign ov_evt_code  = emit_busy ? sel_code : '0;
    assign o_sweep_tick = in_emit && (pending_q == '0) && last_col;

`ifdef KEYPAD_SCAN_RELEASE_EVT_EN
    // The stable bit was already updated in SAMPLE, so it is the new level.
    assign o_evt_press = emit_busy & ov_key_state[sel_code];
`else
    assign o_evt_press = 1'b1;
`endif

endmodule
